// File: rtl/mask_pipe.sv
// ---------------------------------------------------------------------------
// mask_pipe
//
// Purpose:
//   Applies a configurable bitwise mask operation (AND / OR / XOR /
//   pass-through) to each word accepted on a valid/ready input. The
//   transformed words are buffered in a 2-entry FIFO and presented on a
//   valid/ready output. A word is transformed once, using the mask and mode
//   that are current when it is accepted. It is stored already transformed,
//   so later configuration writes never change buffered words.
//
// Optional feature:
//   MASK_PIPE_STATS_EN - when defined, xfer_cnt counts completed output
//                        transfers (16-bit, wrapping). When undefined,
//                        xfer_cnt is tied to zero and no counter exists.
//
// Ports:
//   clk        in   1      rising-edge clock for all state
//   rst_n      in   1      asynchronous active-low reset
//   in_valid   in   1      in_data is valid this cycle
//   in_ready   out  1      block accepts in_data this cycle (registered)
//   in_data    in   WIDTH  operand
//   out_valid  out  1      out_data is valid (registered)
//   out_ready  in   1      consumer accepts out_data
//   out_data   out  WIDTH  masked result (FIFO head)
//   cfg_we     in   1      load cfg_mask / cfg_mode this cycle
//   cfg_mask   in   WIDTH  new mask value
//   cfg_mode   in   2      00 AND, 01 OR, 10 XOR, 11 pass-through
//   xfer_cnt   out  16     completed output transfers (see above)
// ---------------------------------------------------------------------------
module mask_pipe #(
    parameter int          WIDTH      = 16,
    parameter logic [63:0] RESET_MASK = 64'h0000_0000_0000_AAAA,
    parameter logic [1:0]  RESET_MODE = 2'b00
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    input  logic             cfg_we,
    input  logic [WIDTH-1:0] cfg_mask,
    input  logic [1:0]       cfg_mode,
    output logic [15:0]      xfer_cnt
);

    localparam logic [WIDTH-1:0] RESET_MASK_W = RESET_MASK[WIDTH-1:0];

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] head_reg, head_next;
    logic [WIDTH-1:0] tail_reg, tail_next;
    logic [WIDTH-1:0] mask_reg;
    logic [1:0]       mode_reg;
    logic             in_ready_reg;
    logic             out_valid_reg;

    logic             in_xfer;
    logic             out_xfer;
    logic [WIDTH-1:0] xform;

    assign in_xfer   = in_valid & in_ready_reg;
    assign out_xfer  = out_valid_reg & out_ready;
    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign out_data  = head_reg;

    // Transform with the configuration registers (not cfg_*), so a word
    // accepted on the same edge as a cfg_we still sees the old settings.
    always_comb begin
        xform = in_data;
        case (mode_reg)
            2'b00:   xform = in_data & mask_reg;
            2'b01:   xform = in_data | mask_reg;
            2'b10:   xform = in_data ^ mask_reg;
            default: xform = in_data;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= EMPTY;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state and FIFO data movement. The head register is always the
    // oldest word; the tail register is only meaningful in TWO.
    always_comb begin
        state_next = state_reg;
        head_next  = head_reg;
        tail_next  = tail_reg;
        case (state_reg)
            EMPTY: begin
                if (in_xfer) begin
                    head_next  = xform;
                    state_next = ONE;
                end
            end
            ONE: begin
                if (in_xfer && out_xfer) begin
                    head_next = xform;
                end else if (in_xfer) begin
                    tail_next  = xform;
                    state_next = TWO;
                end else if (out_xfer) begin
                    state_next = EMPTY;
                end
            end
            TWO: begin
                // in_ready is low here, so only the output side can move.
                if (out_xfer) begin
                    head_next  = tail_reg;
                    state_next = ONE;
                end
            end
            default: begin
                state_next = EMPTY;
            end
        endcase
    end

    // Handshake flags are registered copies of the next state, which keeps
    // out_ready off any combinational path to in_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_reg      <= '0;
            tail_reg      <= '0;
            in_ready_reg  <= 1'b0;
            out_valid_reg <= 1'b0;
            mask_reg      <= RESET_MASK_W;
            mode_reg      <= RESET_MODE;
        end else begin
            head_reg      <= head_next;
            tail_reg      <= tail_next;
            in_ready_reg  <= (state_next != TWO);
            out_valid_reg <= (state_next != EMPTY);
            if (cfg_we) begin
                mask_reg <= cfg_mask;
                mode_reg <= cfg_mode;
            end
        end
    end

`ifdef MASK_PIPE_STATS_EN
    logic [15:0] xfer_cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xfer_cnt_reg <= 16'd0;
        end else if (out_xfer) begin
            xfer_cnt_reg <= xfer_cnt_reg + 16'd1;
        end
    end

    assign xfer_cnt = xfer_cnt_reg;
`else
    assign xfer_cnt = 16'd0;
`endif

endmodule
